// File: rtl/latch_writer_pkg.sv
// Shared types and elaboration helpers for the latch strobe writer.
// Optional readback checking is enabled with the LATCH_WRITER_CHECK_EN macro.
package latch_writer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Phase counter width: enough bits for the longest phase, never below 1.
    function automatic int cnt_width(input int s, input int p, input int h);
        int m;
        m = 1;
        if (s > m) m = s;
        if (p > m) m = p;
        if (h > m) m = h;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

    // Legal timing parameter ranges.
    function automatic bit params_ok(input int s, input int p, input int h);
        return (s >= 1) && (p >= 1) && (h >= 0);
    endfunction

endpackage

// File: rtl/latch_strobe_writer_phase_counter.sv
// Loadable down-counter with zero flag; times each write phase.
module phase_counter
    import latch_writer_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && (cnt != '0))
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/latch_strobe_writer.sv
// Write side of a level-sensitive D-latch interface: drives d_out and a
// registered enable strobe e_out with programmable setup/pulse/hold cycles.
// Define LATCH_WRITER_CHECK_EN to add q_in readback and the err flag.
module latch_strobe_writer
    import latch_writer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] d_out,
    output logic             e_out,
    output logic             busy,
    output logic             done
`ifdef LATCH_WRITER_CHECK_EN
    ,
    input  logic [WIDTH-1:0] q_in,
    output logic             err
`endif
);

    localparam int CW = cnt_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [CW-1:0] S_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] P_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0] H_LD = (HOLD_CYC > 0) ? CW'(HOLD_CYC - 1) : '0;

    if (!params_ok(SETUP_CYC, PULSE_CYC, HOLD_CYC)) begin : g_bad_params
        $error("latch_strobe_writer: SETUP_CYC>=1, PULSE_CYC>=1, HOLD_CYC>=0 required");
    end

    state_t          state, state_nx;
    logic            e_nx, done_nx, take;
    logic            cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0]   cnt_val;

    phase_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Next-state, strobe and counter control.
    always_comb begin
        state_nx = state;
        e_nx     = e_out;
        done_nx  = 1'b0;
        take     = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nx = SETUP;
                    take     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = S_LD;
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_nx = STROBE;
                    e_nx     = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = P_LD;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            STROBE: begin
                if (cnt_zero) begin
                    e_nx = 1'b0;
                    if (HOLD_CYC > 0) begin
                        state_nx = HOLD;
                        cnt_load = 1'b1;
                        cnt_val  = H_LD;
                    end else begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State and output flops; async reset kills the strobe with no hold phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            e_out <= 1'b0;
            done  <= 1'b0;
            d_out <= '0;
        end else begin
            state <= state_nx;
            e_out <= e_nx;
            done  <= done_nx;
            if (take)
                d_out <= in_data;
        end
    end

`ifdef LATCH_WRITER_CHECK_EN
    logic [WIDTH-1:0] q_smp, q_cmp;

    // With no hold phase the sample edge is also the completion edge.
    assign q_cmp = (HOLD_CYC == 0) ? q_in : q_smp;

    // Sample Q while the latch is still transparent; judge it at completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_smp <= '0;
            err   <= 1'b0;
        end else begin
            if ((state == STROBE) && cnt_zero)
                q_smp <= q_in;
            if (done_nx)
                err <= (q_cmp != d_out);
        end
    end
`endif

endmodule

// File: tb/tb_latch_strobe_writer.sv
// Self-checking bench for latch_strobe_writer: cycle table for one write,
// scoreboard of accepted words checked at each done, plus corner sequences.
module tb_latch_strobe_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, e_out, busy, done;
    logic [7:0] in_data, d_out;
    logic       in_valid2, in_ready2, e_out2, busy2, done2;
    logic [7:0] in_data2, d_out2;
`ifdef LATCH_WRITER_CHECK_EN
    logic [7:0] q_in, q_in2, q_val;
    logic       err, err2, q_loop;
    assign q_in  = q_loop ? d_out : q_val;
    assign q_in2 = d_out2;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [7:0] sb_q[$];
    int         acc_cyc[$];

    always #5 clk = ~clk;

    latch_strobe_writer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .d_out(d_out), .e_out(e_out), .busy(busy), .done(done)
`ifdef LATCH_WRITER_CHECK_EN
        , .q_in(q_in), .err(err)
`endif
    );

    latch_strobe_writer #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .d_out(d_out2), .e_out(e_out2), .busy(busy2), .done(done2)
`ifdef LATCH_WRITER_CHECK_EN
        , .q_in(q_in2), .err(err2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare the latched word on done.
    always @(posedge clk) begin
        logic [7:0] exp_w;
        cyc++;
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb_q.push_back(in_data);
                acc_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                chk("sb_pending", sb_q.size() > 0, 1);
                if (sb_q.size() > 0) begin
                    exp_w = sb_q.pop_front();
                    chk("sb_word", d_out, exp_w);
                end
            end
        end
    end

    task automatic write_word(input logic [7:0] w);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("write_done_seen", done, 1);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] din;
        logic       rdy, e, dn, bsy;
        logic [7:0] d;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        vec_t tbl[7];
        int   n, d0;

        // Row i: outputs in cycle i (after edge i-1), inputs for edge i.
        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
        tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5};

        rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        in_valid2 = 1'b0; in_data2 = 8'h00;
`ifdef LATCH_WRITER_CHECK_EN
        q_loop = 1'b1; q_val = 8'h00;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {e_out, done, busy, d_out}, {1'b0, 1'b0, 1'b0, 8'h00});
        rst_n = 1'b1;

        // Idle after reset stays put.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_state", {in_ready, e_out, done, busy, d_out}, {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
        end

        // Single write of 0xA5, cycle by cycle.
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("tbl_row%0d", i), {in_ready, e_out, done, busy, d_out},
                {tbl[i].rdy, tbl[i].e, tbl[i].dn, tbl[i].bsy, tbl[i].d});
            in_valid = tbl[i].v;
            in_data  = tbl[i].din;
        end

        // Back-to-back with in_valid held: data changes while not ready.
        acc_cyc.delete();
        d0 = done_cnt;
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk);
        in_data = 8'hC3;
        for (int j = 0; j < 6; j++) begin
            if (j < 5) chk("b2b_first_word_held", d_out, 8'h3C);
            else       chk("b2b_second_word", d_out, 8'hC3);
            if (j == 5) in_valid = 1'b0;
            @(negedge clk);
        end
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        chk("b2b_second_done_seen", done, 1);
        @(negedge clk);
        chk("b2b_done_count", done_cnt - d0, 2);
        chk("b2b_accepts", acc_cyc.size(), 2);
        // Four busy cycles plus the done/ready cycle between accepts.
        if (acc_cyc.size() == 2) chk("b2b_accept_spacing", acc_cyc[1] - acc_cyc[0], 5);

        // Zero hold phase, long setup, single-cycle pulse.
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = 8'h0F;
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("nohold_dout", d_out2, 8'h0F);
        for (int j = 0; j < 7; j++) begin
            chk($sformatf("nohold_e_done_j%0d", j), {e_out2, done2},
                {(j == 3) ? 1'b1 : 1'b0, (j == 4) ? 1'b1 : 1'b0});
            @(negedge clk);
        end

        // Reset asserted mid-strobe aborts the write immediately.
        in_valid = 1'b1; in_data = 8'h5A;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!e_out && n < 20) begin @(negedge clk); n++; end
        chk("abort_strobe_seen", e_out, 1);
        #2 rst_n = 1'b0;
        #1 chk("abort_async_clear", {e_out, busy, d_out}, {1'b0, 1'b0, 8'h00});
        sb_q.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
        end
        chk("abort_done_count", done_cnt - d0, 0);
        write_word(8'h99);

`ifdef LATCH_WRITER_CHECK_EN
        q_loop = 1'b1;
        write_word(8'h55);
        chk("chk_match_err", err, 0);
        q_loop = 1'b0; q_val = 8'h54;
        write_word(8'h55);
        chk("chk_mismatch_err", err, 1);
        repeat (3) @(negedge clk);
        chk("chk_err_held", err, 1);
        q_loop = 1'b1;
        write_word(8'hAA);
        chk("chk_err_cleared", err, 0);
`endif

        repeat (2) @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
